// File: rtl/rat_round_ctrl.sv
// -----------------------------------------------------------------------------
// rat_round_ctrl
//
// Round sequencer for the whack-a-rat game on the 8-button / 8-LED board.
// It runs one timed game. During the game it lights a pseudo-random hole for a
// fixed window and judges button presses against that hole. It also keeps the
// score and counts the game seconds down to zero.
//
// Ports
//   clk         in   1  system clock, all logic on posedge
//   reset       in   1  synchronous, active-high reset
//   start       in   1  level; sampled in IDLE/OVER to begin a game
//   button      in   8  debounced buttons, active-high; bit i = hole i
//   rat         out  8  one-hot lit hole; 0 when no rat is shown
//   score       out  8  hits this game, 0..99 (saturating)
//   second      out  8  seconds remaining, GAME_SECONDS..0
//   playing     out  1  high in GAP/SHOW
//   game_over   out  1  high in OVER
//   hit_pulse   out  1  one-cycle pulse on a scored hit
//   miss_pulse  out  1  one-cycle pulse on a wrong press or a rat timeout
//   dbg_state   out  2  current FSM state (0 IDLE, 1 GAP, 2 SHOW, 3 OVER)
//
// Every output except playing/game_over/dbg_state is a register. Those three
// decode the state register directly. A press is judged in the cycle it is
// sampled, and its effect is visible one cycle later.
// -----------------------------------------------------------------------------
module rat_round_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned GAME_SECONDS  = 30,
  parameter int unsigned MOLE_TICKS    = 25000000,
  parameter int unsigned GAP_TICKS     = 5000000,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] button,
  output logic [7:0] rat,
  output logic [7:0] score,
  output logic [7:0] second,
  output logic       playing,
  output logic       game_over,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [1:0] dbg_state
);

  // Counter widths only need to hold 0..N-1.
  localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned MOLE_W = (MOLE_TICKS > 1) ? $clog2(MOLE_TICKS) : 1;
  localparam int unsigned GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [MOLE_W-1:0] MOLE_LAST    = MOLE_W'(MOLE_TICKS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST     = GAP_W'(GAP_TICKS - 1);
  localparam logic [7:0]        SECONDS_INIT = 8'(GAME_SECONDS);
  localparam logic [7:0]        SCORE_MAX    = 8'd99;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_SHOW = 2'd2,
    S_OVER = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t              state;
  logic [7:0]          lfsr;
  logic [7:0]          btn_q;
  logic [2:0]          prev_hole;
  logic [TICK_W-1:0]   tick_cnt;
  logic [MOLE_W-1:0]   mole_cnt;
  logic [GAP_W-1:0]    gap_cnt;

  // Next-state values produced by the combinational process
  state_t              state_d;
  logic [7:0]          lfsr_d;
  logic [2:0]          prev_hole_d;
  logic [TICK_W-1:0]   tick_d;
  logic [MOLE_W-1:0]   mole_d;
  logic [GAP_W-1:0]    gap_d;
  logic [7:0]          rat_d;
  logic [7:0]          score_d;
  logic [7:0]          second_d;
  logic                hit_d;
  logic                miss_d;

  // Helper combinational signals
  logic [7:0]          press;
  logic [2:0]          hole_pick;
  logic                in_play;

  assign playing   = (state == S_GAP) || (state == S_SHOW);
  assign game_over = (state == S_OVER);
  assign dbg_state = state;
  assign in_play   = playing;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state;
    prev_hole_d = prev_hole;
    tick_d      = tick_cnt;
    mole_d      = mole_cnt;
    gap_d       = gap_cnt;
    rat_d       = rat;
    score_d     = score;
    second_d    = second;
    hit_d       = 1'b0;
    miss_d      = 1'b0;

    // The Fibonacci LFSR uses taps 8,6,5,4, which are bits 7,5,4,3.
    lfsr_d = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // A press is a rising edge of a button.
    press = button & ~btn_q;

    // Never light the same hole twice in a row.
    hole_pick = lfsr[2:0];
    if (hole_pick == prev_hole) begin
      hole_pick = lfsr[2:0] + 3'd1;
    end

    unique case (state)
      S_IDLE, S_OVER: begin
        rat_d = 8'd0;
        if (start) begin
          state_d  = S_GAP;
          score_d  = 8'd0;
          second_d = SECONDS_INIT;
          tick_d   = '0;
          gap_d    = '0;
        end
      end

      S_GAP: begin
        rat_d = 8'd0;
        if (gap_cnt == GAP_LAST) begin
          state_d     = S_SHOW;
          rat_d       = 8'd1 << hole_pick;
          prev_hole_d = hole_pick;
          mole_d      = '0;
        end else begin
          gap_d = gap_cnt + GAP_W'(1);
        end
      end

      S_SHOW: begin
        // The hit test comes first. A correct press on the timeout cycle
        // therefore scores as a hit.
        if (press == rat) begin
          hit_d   = 1'b1;
          score_d = (score >= SCORE_MAX) ? SCORE_MAX : score + 8'd1;
          state_d = S_GAP;
          gap_d   = '0;
          rat_d   = 8'd0;
        end else if (press != 8'd0) begin
          miss_d  = 1'b1;
          state_d = S_GAP;
          gap_d   = '0;
          rat_d   = 8'd0;
        end else if (mole_cnt == MOLE_LAST) begin
          miss_d  = 1'b1;
          state_d = S_GAP;
          gap_d   = '0;
          rat_d   = 8'd0;
        end else begin
          mole_d = mole_cnt + MOLE_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The game clock overrides the round FSM when time runs out. The judgement
    // above still keeps its score and its pulse.
    if (in_play) begin
      if (tick_cnt == TICK_LAST) begin
        tick_d = '0;
        if (second != 8'd0) begin
          second_d = second - 8'd1;
        end
        if (second == 8'd1) begin
          state_d = S_OVER;
          rat_d   = 8'd0;
        end
      end else begin
        tick_d = tick_cnt + TICK_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      lfsr       <= LFSR_SEED;
      btn_q      <= 8'd0;
      prev_hole  <= 3'd0;
      tick_cnt   <= '0;
      mole_cnt   <= '0;
      gap_cnt    <= '0;
      rat        <= 8'd0;
      score      <= 8'd0;
      second     <= SECONDS_INIT;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_d;
      lfsr       <= lfsr_d;
      btn_q      <= button;
      prev_hole  <= prev_hole_d;
      tick_cnt   <= tick_d;
      mole_cnt   <= mole_d;
      gap_cnt    <= gap_d;
      rat        <= rat_d;
      score      <= score_d;
      second     <= second_d;
      hit_pulse  <= hit_d;
      miss_pulse <= miss_d;
    end
  end

endmodule

// File: tb/tb_rat_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rat_round_ctrl
//
// Two instances of rat_round_ctrl:
//   dut0 uses the short test configuration (10 ticks/s, 3 s, 5-cycle rat, 2-cycle gap)
//   dut1 is identical except for a 50 s game, which is long enough to reach 99 hits
// A behavioural model of the game runs for each instance, driven by countdowns.
// The model steps on posedge. The outputs are compared with it on every negedge.
// -----------------------------------------------------------------------------
module tb_rat_round_ctrl;

  localparam int TPS   = 10;
  localparam int MOLE  = 5;
  localparam int GAP   = 2;
  localparam int GS_A  = 3;
  localparam int GS_B  = 50;

  localparam int PH_IDLE = 0;
  localparam int PH_GAP  = 1;
  localparam int PH_SHOW = 2;
  localparam int PH_OVER = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [2];
  logic       start_v [2];
  logic [7:0] btn_v   [2];

  logic [7:0] rat_o    [2];
  logic [7:0] score_o  [2];
  logic [7:0] second_o [2];
  logic       playing_o[2];
  logic       over_o   [2];
  logic       hit_o    [2];
  logic       miss_o   [2];
  logic [1:0] dbg_o    [2];

  rat_round_ctrl #(
    .TICKS_PER_SEC(TPS), .GAME_SECONDS(GS_A), .MOLE_TICKS(MOLE),
    .GAP_TICKS(GAP), .LFSR_SEED(8'hA5)
  ) dut0 (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .button(btn_v[0]),
    .rat(rat_o[0]), .score(score_o[0]), .second(second_o[0]),
    .playing(playing_o[0]), .game_over(over_o[0]),
    .hit_pulse(hit_o[0]), .miss_pulse(miss_o[0]), .dbg_state(dbg_o[0])
  );

  rat_round_ctrl #(
    .TICKS_PER_SEC(TPS), .GAME_SECONDS(GS_B), .MOLE_TICKS(MOLE),
    .GAP_TICKS(GAP), .LFSR_SEED(8'hA5)
  ) dut1 (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .button(btn_v[1]),
    .rat(rat_o[1]), .score(score_o[1]), .second(second_o[1]),
    .playing(playing_o[1]), .game_over(over_o[1]),
    .hit_pulse(hit_o[1]), .miss_pulse(miss_o[1]), .dbg_state(dbg_o[1])
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [dut%0d] actual=%0h required=%0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: one game per instance, driven by countdowns
  // ---------------------------------------------------------------------------
  int         m_phase   [2];
  logic [7:0] m_rat     [2];
  logic [7:0] m_score   [2];
  logic [7:0] m_second  [2];
  logic       m_hit     [2];
  logic       m_miss    [2];
  logic [7:0] m_lfsr    [2];
  logic [7:0] m_btn_prev[2];
  int         m_prev    [2];
  int         m_gap_left[2];
  int         m_lit_left[2];
  int         m_sec_left[2];
  bit         m_valid   [2];

  function automatic int gs_of(input int i);
    return (i == 0) ? GS_A : GS_B;
  endfunction

  task automatic model_step(input int i);
    logic [7:0] press;
    logic [7:0] nl;
    int ph;
    int hole;
    bit leave_show;
    if (rst_v[i] === 1'b1) begin
      m_phase[i]    = PH_IDLE;
      m_rat[i]      = 8'd0;
      m_score[i]    = 8'd0;
      m_second[i]   = 8'(gs_of(i));
      m_hit[i]      = 1'b0;
      m_miss[i]     = 1'b0;
      m_lfsr[i]     = 8'hA5;
      m_btn_prev[i] = 8'd0;
      m_prev[i]     = 0;
      m_gap_left[i] = 0;
      m_lit_left[i] = 0;
      m_sec_left[i] = TPS;
      m_valid[i]    = 1'b1;
      return;
    end
    if (!m_valid[i]) return;
    press      = btn_v[i] & ~m_btn_prev[i];
    nl         = {m_lfsr[i][6:0], ^(m_lfsr[i] & 8'hB8)};
    ph         = m_phase[i];
    m_hit[i]   = 1'b0;
    m_miss[i]  = 1'b0;
    leave_show = 1'b0;
    case (ph)
      PH_IDLE, PH_OVER: begin
        m_rat[i] = 8'd0;
        if (start_v[i]) begin
          m_phase[i]    = PH_GAP;
          m_score[i]    = 8'd0;
          m_second[i]   = 8'(gs_of(i));
          m_sec_left[i] = TPS;
          m_gap_left[i] = GAP;
        end
      end
      PH_GAP: begin
        m_gap_left[i]--;
        if (m_gap_left[i] == 0) begin
          hole = m_lfsr[i] % 8;
          if (hole == m_prev[i]) hole = (hole + 1) % 8;
          m_rat[i]      = 8'(1 << hole);
          m_prev[i]     = hole;
          m_lit_left[i] = MOLE;
          m_phase[i]    = PH_SHOW;
        end
      end
      PH_SHOW: begin
        if (press == m_rat[i]) begin
          m_hit[i]   = 1'b1;
          m_score[i] = (m_score[i] >= 8'd99) ? 8'd99 : m_score[i] + 8'd1;
          leave_show = 1'b1;
        end else if (press != 8'd0) begin
          m_miss[i]  = 1'b1;
          leave_show = 1'b1;
        end else begin
          m_lit_left[i]--;
          if (m_lit_left[i] == 0) begin
            m_miss[i]  = 1'b1;
            leave_show = 1'b1;
          end
        end
        if (leave_show) begin
          m_phase[i]    = PH_GAP;
          m_gap_left[i] = GAP;
          m_rat[i]      = 8'd0;
        end
      end
      default: ;
    endcase
    if (ph == PH_GAP || ph == PH_SHOW) begin
      m_sec_left[i]--;
      if (m_sec_left[i] == 0) begin
        m_sec_left[i] = TPS;
        m_second[i]   = m_second[i] - 8'd1;
        if (m_second[i] == 8'd0) begin
          m_phase[i] = PH_OVER;
          m_rat[i]   = 8'd0;
        end
      end
    end
    m_lfsr[i]     = nl;
    m_btn_prev[i] = btn_v[i];
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
  end

  // ---------------------------------------------------------------------------
  // Compare process: every output, every cycle, once the model is valid
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i]) begin
        chk("rat",        i, 32'(rat_o[i]),     32'(m_rat[i]));
        chk("score",      i, 32'(score_o[i]),   32'(m_score[i]));
        chk("second",     i, 32'(second_o[i]),  32'(m_second[i]));
        chk("playing",    i, 32'(playing_o[i]), 32'(m_phase[i] == PH_GAP || m_phase[i] == PH_SHOW));
        chk("game_over",  i, 32'(over_o[i]),    32'(m_phase[i] == PH_OVER));
        chk("hit_pulse",  i, 32'(hit_o[i]),     32'(m_hit[i]));
        chk("miss_pulse", i, 32'(miss_o[i]),    32'(m_miss[i]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic wait_rat(input int i);
    int k = 0;
    while (m_rat[i] == 8'd0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (m_rat[i] == 8'd0) chk("wait_rat_timeout", i, 32'd0, 32'd1);
  endtask

  task automatic wait_over(input int i, input int budget);
    int k = 0;
    while (m_phase[i] != PH_OVER && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (m_phase[i] != PH_OVER) chk("wait_over_timeout", i, 32'd0, 32'd1);
  endtask

  // Press every rat on the cycle it appears, and release on the next cycle.
  task automatic hit_all(input int i, input int budget);
    int k = 0;
    while (m_phase[i] != PH_OVER && k < budget) begin
      if (btn_v[i] != 8'd0) btn_v[i] = 8'd0;
      else if (m_rat[i] != 8'd0) btn_v[i] = m_rat[i];
      @(negedge clk);
      k++;
    end
    btn_v[i] = 8'd0;
    if (m_phase[i] != PH_OVER) chk("hit_all_timeout", i, 32'd0, 32'd1);
  endtask

  task automatic pulse_start(input int i);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] rot;
    logic [7:0] prev_rat;
    int lit;
    for (int i = 0; i < 2; i++) begin
      rst_v[i]   = 1'b1;
      start_v[i] = 1'b0;
      btn_v[i]   = 8'd0;
    end
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_rat",     0, 32'(rat_o[0]),     32'd0);
    chk("rst_score",   0, 32'(score_o[0]),   32'd0);
    chk("rst_second",  0, 32'(second_o[0]),  32'd3);
    chk("rst_playing", 0, 32'(playing_o[0]), 32'd0);
    chk("rst_over",    0, 32'(over_o[0]),    32'd0);

    // Start, then the first rat: LFSR A5 -> 4A -> 95, so the hole is 5.
    rst_v[0] = 1'b0;
    pulse_start(0);
    chk("start_second",  0, 32'(second_o[0]),  32'd3);
    chk("start_score",   0, 32'(score_o[0]),   32'd0);
    chk("start_playing", 0, 32'(playing_o[0]), 32'd1);
    @(negedge clk);
    chk("gap_dark", 0, 32'(rat_o[0]), 32'd0);
    @(negedge clk);
    chk("first_rat", 0, 32'(rat_o[0]), 32'h20);

    // Correct press one cycle after the rat appears
    @(negedge clk);
    btn_v[0] = m_rat[0];
    @(negedge clk);
    chk("hit_pulse_lit", 0, 32'(hit_o[0]),   32'd1);
    chk("hit_score",     0, 32'(score_o[0]), 32'd1);
    chk("hit_rat_clear", 0, 32'(rat_o[0]),   32'd0);
    btn_v[0] = 8'd0;

    // Wrong single bit
    wait_rat(0);
    rot = {m_rat[0][6:0], m_rat[0][7]};
    btn_v[0] = rot;
    @(negedge clk);
    chk("wrong_miss",  0, 32'(miss_o[0]),  32'd1);
    chk("wrong_score", 0, 32'(score_o[0]), 32'd1);
    btn_v[0] = 8'd0;

    // Two bits that include the lit one
    wait_rat(0);
    rot = {m_rat[0][6:0], m_rat[0][7]};
    btn_v[0] = m_rat[0] | rot;
    @(negedge clk);
    chk("multi_miss",  0, 32'(miss_o[0]),  32'd1);
    chk("multi_hit",   0, 32'(hit_o[0]),   32'd0);
    chk("multi_score", 0, 32'(score_o[0]), 32'd1);
    btn_v[0] = 8'd0;

    // No press: lit exactly MOLE cycles, then a miss and a different hole
    wait_rat(0);
    lit = 0;
    prev_rat = 8'd0;
    while (rat_o[0] != 8'd0 && lit < 20) begin
      prev_rat = rat_o[0];
      lit++;
      @(negedge clk);
    end
    chk("lit_cycles",   0, 32'(lit),       32'd5);
    chk("timeout_miss", 0, 32'(miss_o[0]), 32'd1);
    wait_rat(0);
    chk("new_hole", 0, 32'(rat_o[0] != prev_rat), 32'd1);

    // Let time run out
    wait_over(0, 100);
    chk("over_second",  0, 32'(second_o[0]),  32'd0);
    chk("over_flag",    0, 32'(over_o[0]),    32'd1);
    chk("over_rat",     0, 32'(rat_o[0]),     32'd0);
    chk("over_playing", 0, 32'(playing_o[0]), 32'd0);
    chk("over_score",   0, 32'(score_o[0]),   32'd1);
    repeat (3) @(negedge clk);
    chk("over_hold", 0, 32'(second_o[0]), 32'd0);

    // Restart and hit every rat. The rats then land every 3 cycles, so the
    // tenth hit falls on the final tick.
    pulse_start(0);
    chk("restart_score",  0, 32'(score_o[0]),  32'd0);
    chk("restart_second", 0, 32'(second_o[0]), 32'd3);
    hit_all(0, 100);
    chk("final_tick_hit",   0, 32'(hit_o[0]),    32'd1);
    chk("final_tick_score", 0, 32'(score_o[0]),  32'd10);
    chk("final_tick_over",  0, 32'(over_o[0]),   32'd1);

    // Reset mid-SHOW with a press pending
    pulse_start(0);
    wait_rat(0);
    btn_v[0] = m_rat[0];
    @(negedge clk);
    btn_v[0] = 8'd0;
    wait_rat(0);
    rst_v[0] = 1'b1;
    btn_v[0] = m_rat[0];
    @(negedge clk);
    chk("midrst_rat",     0, 32'(rat_o[0]),     32'd0);
    chk("midrst_score",   0, 32'(score_o[0]),   32'd0);
    chk("midrst_second",  0, 32'(second_o[0]),  32'd3);
    chk("midrst_hit",     0, 32'(hit_o[0]),     32'd0);
    chk("midrst_miss",    0, 32'(miss_o[0]),    32'd0);
    chk("midrst_playing", 0, 32'(playing_o[0]), 32'd0);
    rst_v[0] = 1'b0;
    btn_v[0] = 8'd0;

    // Random play against the model
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(0, 9);
      start_v[0] = ($urandom_range(0, 19) == 0);
      rst_v[0]   = ($urandom_range(0, 299) == 0);
      if (m_rat[0] != 8'd0 && r < 5) btn_v[0] = m_rat[0];
      else if (r < 7) btn_v[0] = 8'($urandom_range(0, 255));
      else btn_v[0] = 8'd0;
      @(negedge clk);
    end
    rst_v[0]   = 1'b0;
    start_v[0] = 1'b0;
    btn_v[0]   = 8'd0;

    // Long game on dut1: the score saturates at 99
    rst_v[1] = 1'b0;
    @(negedge clk);
    pulse_start(1);
    hit_all(1, 1000);
    chk("sat_score", 1, 32'(score_o[1]),  32'd99);
    chk("sat_over",  1, 32'(over_o[1]),   32'd1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Overall time bound
  initial begin
    #1000000;
    n_assert++;
    n_fail++;
    $display("FAIL watchdog [tb] actual=timeout required=finish at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
